fifo_packer: RTL and testbench

FIFO_PACKER -- requirements
Module: fifo_packer

---
 rtl/fifo_packer.sv | 89 ++++++++
 tb/tb_fifo_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// Packs PACK consecutive FIFO words into one wide beat with a valid/ready output.
// Optional partial-beat flush on idle timeout is enabled by defining FIFO_PACKER_FLUSH_EN.
module fifo_packer #(
    parameter int WIDTH   = 32,
    parameter int PACK    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          fifo_rd_en,
    input  logic [WIDTH-1:0]              fifo_rd_data,
    input  logic                          fifo_rd_valid,
    output logic [WIDTH*PACK-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(PACK+1)-1:0]     out_count
);

    localparam int CW = $clog2(PACK+1);

    if (PACK < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_packer: PACK must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] lanes [PACK];

`ifdef FIFO_PACKER_FLUSH_EN
    localparam int IW = $clog2(TIMEOUT+1);
    logic [IW-1:0]    idle;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FILL;
            count <= '0;
            for (int k = 0; k < PACK; k++) lanes[k] <= '0;
`ifdef FIFO_PACKER_FLUSH_EN
            idle  <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (fifo_rd_valid) begin
                        for (int k = 0; k < PACK; k++)
                            if (count == CW'(k)) lanes[k] <= fifo_rd_data;
                        count <= count + CW'(1);
                        if (count == CW'(PACK-1)) state <= HOLD;
`ifdef FIFO_PACKER_FLUSH_EN
                        idle <= '0;
                    end else if (count != '0) begin
                        // a partial beat is pushed out once the FIFO has been dry long enough
                        if (idle == IW'(TIMEOUT-1)) begin
                            state <= HOLD;
                            idle  <= '0;
                        end else begin
                            idle <= idle + IW'(1);
                        end
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        // the read issued alongside the handshake starts the next beat without a bubble
                        for (int k = 0; k < PACK; k++) begin
                            if (k == 0) lanes[k] <= fifo_rd_valid ? fifo_rd_data : '0;
                            else        lanes[k] <= '0;
                        end
                        count <= fifo_rd_valid ? CW'(1) : '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    always_comb begin
        out_valid  = (state == HOLD);
        out_count  = (state == HOLD) ? count : '0;
        fifo_rd_en = reset ? 1'b0 : ((state == HOLD) ? out_ready : 1'b1);
        out_data   = '0;
        for (int k = 0; k < PACK; k++) out_data[k*WIDTH +: WIDTH] = lanes[k];
    end

endmodule

// File: tb/tb_fifo_packer.sv
// Directed and randomized checks of fifo_packer against a queue-based beat model.
module tb_fifo_packer;

    localparam int W = 32;
    localparam int P = 4;
    localparam int T = 8;

    logic            clock;
    logic            reset;
    logic            fifo_rd_en;
    logic [W-1:0]    fifo_rd_data;
    logic            fifo_rd_valid;
    logic [W*P-1:0]  out_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_count;

    fifo_packer #(.WIDTH(W), .PACK(P), .TIMEOUT(T)) dut (
        .clock        (clock),
        .reset        (reset),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_valid(fifo_rd_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int beats  = 0;

    // reference: words gathered for the current beat, whether a beat is on offer, idle run length
    logic [W-1:0] acc[$];
    bit           held;
    int           idle;

    task automatic check(input string tag, input logic [W*P-1:0] obs, input logic [W*P-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*P-1:0] model_data();
        logic [W*P-1:0] d = '0;
        for (int k = 0; k < acc.size(); k++) d[k*W +: W] = acc[k];
        return d;
    endfunction

    task automatic model_reset();
        acc.delete();
        held = 0;
        idle = 0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic r);
        if (held) begin
            if (r) begin
                acc.delete();
                held = 0;
                idle = 0;
                if (v) acc.push_back(d);
            end
        end else if (v) begin
            acc.push_back(d);
            idle = 0;
            if (acc.size() == P) held = 1;
        end else if (acc.size() > 0) begin
`ifdef FIFO_PACKER_FLUSH_EN
            idle++;
            if (idle == T) begin
                held = 1;
                idle = 0;
            end
`endif
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        fifo_rd_valid = v;
        fifo_rd_data  = d;
        out_ready     = r;
        #1;
        check("rd_en", fifo_rd_en, held ? r : 1'b1);
        check("out_valid", out_valid, held);
        check("out_count", out_count, held ? acc.size() : 0);
        check("out_data", out_data, model_data());
        if (out_valid) beats++;
        @(posedge clock);
        model_step(v, d, r);
        @(negedge clock);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_count", out_count, 0);
        check("rst_out_data", out_data, '0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [W-1:0] wa, wb, wc, wd, we;

    initial begin
        reset = 1'b1;
        fifo_rd_valid = 1'b0;
        fifo_rd_data  = '0;
        out_ready     = 1'b0;
        model_reset();
        #1;
        check("reset_rd_en", fifo_rd_en, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_count", out_count, 0);
        check("reset_out_data", out_data, '0);
        @(negedge clock);
        reset = 1'b0;

        // four words, beat offered the cycle after the last capture
        wa = 32'hA000_0001; wb = 32'hB000_0002; wc = 32'hC000_0003; wd = 32'hD000_0004;
        cycle(1, wa, 1); cycle(1, wb, 1); cycle(1, wc, 1); cycle(1, wd, 1);
        check("first_beat_valid", out_valid, 1'b1);
        check("first_beat_data", out_data, {wd, wc, wb, wa});
        check("first_beat_count", out_count, 4);
        cycle(0, '0, 1);

        // 12 back-to-back words with constant ready
        beats = 0;
        for (int i = 0; i < 12; i++) cycle(1, 32'h0000_0100 + i, 1);
        cycle(0, '0, 1);
        check("b2b_beats", beats, 3);

        // backpressure for five cycles, then release with a new word
        for (int i = 0; i < 4; i++) cycle(1, 32'h0000_0200 + i, 1);
        for (int i = 0; i < 5; i++) cycle(0, '0, 0);
        we = 32'hE000_0005;
        cycle(1, we, 1);
        check("release_lane0", out_data, {96'h0, we});
        check("release_not_valid", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1, 32'h0000_0300 + i, 1);
        cycle(0, '0, 1);

        // empty FIFO for 20 cycles
        for (int i = 0; i < 20; i++) cycle(0, '0, 1);
        check("empty_count", out_count, 0);

        // two words then eight dry cycles
        cycle(1, 32'h0000_0401, 1);
        cycle(1, 32'h0000_0402, 1);
        for (int i = 0; i < 8; i++) cycle(0, '0, 1);
`ifdef FIFO_PACKER_FLUSH_EN
        check("flush_valid", out_valid, 1'b1);
        check("flush_count", out_count, 2);
        check("flush_data", out_data, {64'h0, 32'h0000_0402, 32'h0000_0401});
        cycle(0, '0, 1);
`else
        check("noflush_valid", out_valid, 1'b0);
        for (int i = 0; i < 8; i++) cycle(0, '0, 1);
        check("noflush_still_idle", out_valid, 1'b0);
`endif

        // asynchronous reset while three words are gathered
        #2;
        async_reset();
        cycle(1, 32'h0000_0501, 1); cycle(1, 32'h0000_0502, 1); cycle(1, 32'h0000_0503, 1);
        #2;
        async_reset();
        wa = 32'h0000_0601; wb = 32'h0000_0602; wc = 32'h0000_0603; wd = 32'h0000_0604;
        cycle(1, wa, 1); cycle(1, wb, 1); cycle(1, wc, 1); cycle(1, wd, 1);
        check("post_reset_beat", out_data, {wd, wc, wb, wa});
        check("post_reset_count", out_count, 4);
        cycle(0, '0, 1);

        // random traffic and backpressure
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
